// File: rtl/wbu_scoreboard.sv
// Writeback unit for the RV32E register file's EXU and LSU write ports, with a 16-entry busy scoreboard.
// Optional performance counters (stall_cycles, wb_count) are present when the WBU_PERF_EN macro is defined.
module wbu_scoreboard #(
  parameter int NREG = 16,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            issue_stall,
  input  logic            exu_in_valid,
  output logic            exu_in_ready,
  input  logic [4:0]      exu_in_rd,
  input  logic [XLEN-1:0] exu_in_data,
  input  logic            lsu_in_valid,
  output logic            lsu_in_ready,
  input  logic [4:0]      lsu_in_rd,
  input  logic [XLEN-1:0] lsu_in_data,
  output logic            exu_write,
  output logic [4:0]      exu_rd_addr,
  output logic [XLEN-1:0] exu_rd_data,
  output logic            lsu_write,
  output logic [4:0]      lsu_rd_addr,
  output logic [XLEN-1:0] lsu_rd_data,
  output logic [NREG-1:0] busy_vec,
  output logic            collide_err
`ifdef WBU_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     wb_count
`endif
);

  // Only the low four index bits address the RV32E register file.
  logic [3:0] i_rd, i_rs1, i_rs2, e_idx, l_idx;
  assign i_rd  = issue_rd[3:0];
  assign i_rs1 = issue_rs1[3:0];
  assign i_rs2 = issue_rs2[3:0];
  assign e_idx = exu_in_rd[3:0];
  assign l_idx = lsu_in_rd[3:0];

  logic unused_idx_hi;
  assign unused_idx_hi = ^{issue_rd[4], issue_rs1[4], issue_rs2[4], exu_in_rd[4], lsu_in_rd[4]};

  logic [NREG-1:0] busy_q, busy_d;
  logic            exu_write_q, exu_write_d;
  logic [3:0]      exu_addr_q, exu_addr_d;
  logic [XLEN-1:0] exu_data_q, exu_data_d;
  logic            lsu_write_q, lsu_write_d;
  logic [3:0]      lsu_addr_q, lsu_addr_d;
  logic [XLEN-1:0] lsu_data_q, lsu_data_d;
  logic            collide_q, collide_d;
  logic            collide;

  // Same-rd collision: LSU goes first, EXU is held off for one cycle.
  assign collide      = exu_in_valid && lsu_in_valid && (e_idx == l_idx) && (e_idx != 4'd0);
  assign exu_in_ready = !collide;
  assign lsu_in_ready = 1'b1;

  assign issue_stall = issue_valid &&
                       (((i_rs1 != 4'd0) && busy_q[i_rs1]) ||
                        ((i_rs2 != 4'd0) && busy_q[i_rs2]) ||
                        ((i_rd  != 4'd0) && busy_q[i_rd]));

  always_comb begin
    exu_write_d = exu_in_valid && exu_in_ready && (e_idx != 4'd0);
    exu_addr_d  = exu_addr_q;
    exu_data_d  = exu_data_q;
    if (exu_write_d) begin
      exu_addr_d = e_idx;
      exu_data_d = exu_in_data;
    end
    lsu_write_d = lsu_in_valid && lsu_in_ready && (l_idx != 4'd0);
    lsu_addr_d  = lsu_addr_q;
    lsu_data_d  = lsu_data_q;
    if (lsu_write_d) begin
      lsu_addr_d = l_idx;
      lsu_data_d = lsu_in_data;
    end
    collide_d = collide_q || collide;
  end

  // Clears come from the strobes committing this edge; a same-index set overrides them.
  always_comb begin
    busy_d = busy_q;
    if (exu_write_q) busy_d[exu_addr_q] = 1'b0;
    if (lsu_write_q) busy_d[lsu_addr_q] = 1'b0;
    if (issue_valid && !issue_stall && (i_rd != 4'd0)) busy_d[i_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      exu_write_q <= 1'b0;
      exu_addr_q  <= '0;
      exu_data_q  <= '0;
      lsu_write_q <= 1'b0;
      lsu_addr_q  <= '0;
      lsu_data_q  <= '0;
      collide_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      exu_write_q <= exu_write_d;
      exu_addr_q  <= exu_addr_d;
      exu_data_q  <= exu_data_d;
      lsu_write_q <= lsu_write_d;
      lsu_addr_q  <= lsu_addr_d;
      lsu_data_q  <= lsu_data_d;
      collide_q   <= collide_d;
    end
  end

  assign busy_vec    = busy_q;
  assign exu_write   = exu_write_q;
  assign exu_rd_addr = {1'b0, exu_addr_q};
  assign exu_rd_data = exu_data_q;
  assign lsu_write   = lsu_write_q;
  assign lsu_rd_addr = {1'b0, lsu_addr_q};
  assign lsu_rd_data = lsu_data_q;
  assign collide_err = collide_q;

`ifdef WBU_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    stall_cnt_d = issue_stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    wb_cnt_d    = (exu_write_q || lsu_write_q) ? wb_cnt_q + 32'd1 : wb_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign wb_count     = wb_cnt_q;
`endif

endmodule

// File: tb/tb_wbu_scoreboard.sv
// Directed, table-driven bench for wbu_scoreboard: each row drives one cycle and checks that cycle's outputs.
module tb_wbu_scoreboard;

  logic        clk, rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        exu_in_valid, exu_in_ready;
  logic [4:0]  exu_in_rd;
  logic [31:0] exu_in_data;
  logic        lsu_in_valid, lsu_in_ready;
  logic [4:0]  lsu_in_rd;
  logic [31:0] lsu_in_data;
  logic        exu_write, lsu_write;
  logic [4:0]  exu_rd_addr, lsu_rd_addr;
  logic [31:0] exu_rd_data, lsu_rd_data;
  logic [15:0] busy_vec;
  logic        collide_err;
`ifdef WBU_PERF_EN
  logic [31:0] stall_cycles, wb_count;
`endif

  wbu_scoreboard #(.NREG(16), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .exu_in_valid(exu_in_valid), .exu_in_ready(exu_in_ready),
    .exu_in_rd(exu_in_rd), .exu_in_data(exu_in_data),
    .lsu_in_valid(lsu_in_valid), .lsu_in_ready(lsu_in_ready),
    .lsu_in_rd(lsu_in_rd), .lsu_in_data(lsu_in_data),
    .exu_write(exu_write), .exu_rd_addr(exu_rd_addr), .exu_rd_data(exu_rd_data),
    .lsu_write(lsu_write), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .busy_vec(busy_vec), .collide_err(collide_err)
`ifdef WBU_PERF_EN
    , .stall_cycles(stall_cycles), .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird, irs1, irs2;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        x_stall, x_erdy, x_lrdy;
    logic        x_ew;
    logic [4:0]  x_ea;
    logic [31:0] x_ed;
    logic        x_lw;
    logic [4:0]  x_la;
    logic [31:0] x_ld;
    logic [15:0] x_busy;
    logic        x_col;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic iv, input logic [4:0] ird, input logic [4:0] irs1, input logic [4:0] irs2,
                              input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic x_stall, input logic x_erdy, input logic x_lrdy,
                              input logic x_ew, input logic [4:0] x_ea, input logic [31:0] x_ed,
                              input logic x_lw, input logic [4:0] x_la, input logic [31:0] x_ld,
                              input logic [15:0] x_busy, input logic x_col);
    vec_t v;
    v.iv = iv; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
    v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.x_stall = x_stall; v.x_erdy = x_erdy; v.x_lrdy = x_lrdy;
    v.x_ew = x_ew; v.x_ea = x_ea; v.x_ed = x_ed;
    v.x_lw = x_lw; v.x_la = x_la; v.x_ld = x_ld;
    v.x_busy = x_busy; v.x_col = x_col;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_rd = v.ird; issue_rs1 = v.irs1; issue_rs2 = v.irs2;
    exu_in_valid = v.ev; exu_in_rd = v.erd; exu_in_data = v.ed;
    lsu_in_valid = v.lv; lsu_in_rd = v.lrd; lsu_in_data = v.ld;
  endtask

  vec_t idle;
`ifdef WBU_PERF_EN
  logic [31:0] wb_before;
`endif

  initial begin
    //                iv ird irs1 irs2 ev erd ed         lv lrd ld          stl erdy lrdy ew ea ed          lw la ld          busy      col
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    // basic EXU writeback of x3
    vecs[1]  = mk(1, 3, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    vecs[2]  = mk(0, 0, 0, 0,  1, 3, 32'h1234,   0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0008, 0);
    vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  1, 3, 32'h1234,   0, 0, 0,          16'h0008, 0);
    vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    // RAW on x7 resolved by an LSU writeback
    vecs[5]  = mk(1, 7, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    vecs[6]  = mk(1, 0, 7, 0,  0, 0, 0,          1, 7, 32'hAAAA,   1, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0080, 0);
    vecs[7]  = mk(1, 0, 7, 0,  0, 0, 0,          0, 0, 0,          1, 1, 1,  0, 0, 0,          1, 7, 32'hAAAA,   16'h0080, 0);
    vecs[8]  = mk(1, 0, 7, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    // WAW on x4, x0 handling
    vecs[9]  = mk(1, 4, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    vecs[10] = mk(1, 4, 0, 0,  0, 0, 0,          0, 0, 0,          1, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0010, 0);
    vecs[11] = mk(1, 0, 0, 0,  1, 0, 32'h5555,   0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0010, 0);
    vecs[12] = mk(0, 0, 0, 0,  1, 4, 32'h4444,   0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0010, 0);
    vecs[13] = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  1, 4, 32'h4444,   0, 0, 0,          16'h0010, 0);
    vecs[14] = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    // same-rd collision on x9
    vecs[15] = mk(0, 0, 0, 0,  1, 9, 32'h11,     1, 9, 32'h22,     0, 0, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 0);
    vecs[16] = mk(0, 0, 0, 0,  1, 9, 32'h11,     0, 0, 0,          0, 1, 1,  0, 0, 0,          1, 9, 32'h22,     16'h0000, 1);
    vecs[17] = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  1, 9, 32'h11,     0, 0, 0,          16'h0000, 1);
    // dual write x1/x2
    vecs[18] = mk(1, 1, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 1);
    vecs[19] = mk(1, 2, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0002, 1);
    vecs[20] = mk(0, 0, 0, 0,  1, 1, 32'h101,    1, 2, 32'h202,    0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0006, 1);
    vecs[21] = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  1, 1, 32'h101,    1, 2, 32'h202,    16'h0006, 1);
    vecs[22] = mk(0, 0, 0, 0,  0, 0, 0,          0, 0, 0,          0, 1, 1,  0, 0, 0,          0, 0, 0,          16'h0000, 1);
    idle = vecs[0];

    drive(idle);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_exu_write", 32'(exu_write), 32'h0);
    chk("rst_lsu_write", 32'(lsu_write), 32'h0);
    chk("rst_exu_addr", 32'(exu_rd_addr), 32'h0);
    chk("rst_lsu_data", lsu_rd_data, 32'h0);
    chk("rst_collide", 32'(collide_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
`ifdef WBU_PERF_EN
      if (i == 21) wb_before = wb_count;
`endif
      #1;
      chk($sformatf("v%0d_stall", i), 32'(issue_stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d_exu_ready", i), 32'(exu_in_ready), 32'(vecs[i].x_erdy));
      chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_in_ready), 32'(vecs[i].x_lrdy));
      chk($sformatf("v%0d_exu_write", i), 32'(exu_write), 32'(vecs[i].x_ew));
      chk($sformatf("v%0d_lsu_write", i), 32'(lsu_write), 32'(vecs[i].x_lw));
      chk($sformatf("v%0d_busy", i), 32'(busy_vec), 32'(vecs[i].x_busy));
      chk($sformatf("v%0d_collide", i), 32'(collide_err), 32'(vecs[i].x_col));
      if (vecs[i].x_ew) begin
        chk($sformatf("v%0d_exu_addr", i), 32'(exu_rd_addr), 32'(vecs[i].x_ea));
        chk($sformatf("v%0d_exu_data", i), exu_rd_data, vecs[i].x_ed);
      end
      if (vecs[i].x_lw) begin
        chk($sformatf("v%0d_lsu_addr", i), 32'(lsu_rd_addr), 32'(vecs[i].x_la));
        chk($sformatf("v%0d_lsu_data", i), lsu_rd_data, vecs[i].x_ld);
      end
`ifdef WBU_PERF_EN
      if (i == 22) chk("perf_wb_dual", wb_count - wb_before, 32'd1);
`endif
    end

    // reset between acceptance and commit drops the in-flight write
    @(negedge clk);
    drive(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 1, 5, 32'hDEAD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    #1;
    chk("mid_busy_set", 32'(busy_vec), 32'h0020);
    @(negedge clk);
    drive(idle);
    #1;
    chk("mid_strobe_pending", 32'(exu_write), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exu_write", 32'(exu_write), 32'h0);
    chk("mid_rst_busy", 32'(busy_vec), 32'h0);
    chk("mid_rst_collide", 32'(collide_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_exu_write", 32'(exu_write), 32'h0);
    chk("post_rst_busy", 32'(busy_vec), 32'h0);
`ifdef WBU_PERF_EN
    chk("post_rst_wb_count", wb_count, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbu_scoreboard.md
Name: wbu_scoreboard

Overview:
- Writeback unit on the producer side of the RV32E register file's two write ports (EXU path and LSU path).
- Accepts EXU and LSU results over valid/ready handshakes and drives registered, one-cycle write strobes to the register file.
- Keeps a 16-entry busy scoreboard so that decode stalls on RAW and WAW hazards against pending writes.

Parameters:
- NREG, 16, number of GPRs tracked (RV32E). Register index width is 4 bits.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode presents an instruction
- issue_rd  in  5  destination register (0 means no write)
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_stall  out  1  combinational hazard stall to decode
- exu_in_valid  in  1  EXU result valid
- exu_in_ready  out  1  EXU result accepted when valid&&ready
- exu_in_rd  in  5  EXU destination
- exu_in_data  in  XLEN  EXU result
- lsu_in_valid  in  1  LSU result valid
- lsu_in_ready  out  1  LSU result accepted when valid&&ready
- lsu_in_rd  in  5  LSU destination
- lsu_in_data  in  XLEN  LSU load data
- exu_write  out  1  regfile EXU write enable (registered)
- exu_rd_addr  out  5  regfile EXU write address (registered)
- exu_rd_data  out  XLEN  regfile EXU write data (registered)
- lsu_write  out  1  regfile LSU write enable (registered)
- lsu_rd_addr  out  5  regfile LSU write address (registered)
- lsu_rd_data  out  XLEN  regfile LSU write data (registered)
- busy_vec  out  NREG  scoreboard state, bit i = xi has a pending write
- collide_err  out  1  sticky flag: simultaneous EXU/LSU valid to the same nonzero rd

Behaviour:
- Reset (rst_n=0, async):
  - busy_vec=0, exu_write=0, lsu_write=0, all rd_addr/rd_data outputs=0, collide_err=0.
  - In-flight results are dropped.
- Address rules:
  - Only bits [3:0] of any rd/rs index the scoreboard.
  - rd==0 never sets busy and never produces a write strobe; the handshake still completes.
- Hazard stall:
  - issue_stall = issue_valid && (busy[rs1] || busy[rs2] || busy[rd]), where each term applies only when that field is nonzero.
- Scoreboard set:
  - At the edge where issue_valid && !issue_stall && issue_rd!=0, busy[issue_rd] <= 1.
- Write pipeline (latency 1):
  - An accepted EXU/LSU result loads its output register at edge N.
  - The *_write strobe is high for exactly cycle N+1, and the regfile commits at edge N+1.
  - busy[rd] clears at that same edge N+1.
  - A source read issued in cycle N+2 therefore sees the new value through the regfile's registered read.
- Ready:
  - exu_in_ready=1 and lsu_in_ready=1 except on a same-rd collision (both valid, equal nonzero rd[3:0]).
  - On collision: LSU is accepted, exu_in_ready=0 for that cycle, EXU is accepted the next cycle, and collide_err is set (sticky until reset).
- Simultaneous set/clear: set wins if both target the same index in one cycle. This cannot arise legally, because issue stalls on busy rd.
- A result arriving for a non-busy rd is still written; the scoreboard is unchanged.

Optional Feature:
- Macro WBU_PERF_EN.
- Defined: add outputs stall_cycles (32) and wb_count (32).
  - stall_cycles counts cycles with issue_stall=1.
  - wb_count counts cycles with exu_write||lsu_write.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: issue rd=5, accept EXU rd=5 data=0xDEAD, assert rst_n=0 before edge N+1 -> exu_write=0, busy_vec=0, no write emitted.
- Basic EXU writeback: issue rd=3 (busy_vec=0x0008); EXU valid rd=3 data=0x1234 at edge N -> exu_write=1, exu_rd_addr=3, exu_rd_data=0x1234 in cycle N+1; busy_vec=0 in cycle N+2.
- RAW stall: busy x7; issue rs1=7 -> issue_stall=1 until the LSU writeback of x7 commits; issue_stall=0 from cycle N+2.
- WAW stall and x0: issue rd=4 twice back-to-back -> second stalls. Issue rd=0 -> never stalls, busy_vec unchanged; EXU rd=0 -> exu_write stays 0, exu_in_ready=1.
- Collision: both valid, rd=9, EXU 0x11, LSU 0x22 -> lsu_write=1 with 0x22 first, exu_write=1 with 0x11 one cycle later; exu_in_ready=0 for one cycle; collide_err=1.
- Dual write: EXU rd=1 and LSU rd=2 in the same cycle -> both strobes high in the next cycle; busy bits 1 and 2 clear together. With WBU_PERF_EN, wb_count increments by 1.
